apb_mem_slave: RTL and testbench

- Parametrised APB memory-mapped slave: single-port RAM behind an APB3-style completer interface.
- Generalised in data width, address width and depth; adds programmable wait states, PSLVERR on out-of-range access, and a proper SETUP/ACCESS state machine with registered PREADY.
- Sits on the APB segment behind the decoder, one instance per PSEL line.

---
 rtl/apb_pkg.sv | 13 +
 rtl/apb_sp_ram.sv | 23 ++
 rtl/apb_mem_slave.sv | 115 +++++++++++
 tb/tb_apb_mem_slave.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB memory slave.
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam int   CNT_W      = 4;
  localparam logic APB_OKAY   = 1'b0;
  localparam logic APB_SLVERR = 1'b1;

endpackage

// File: rtl/apb_sp_ram.sv
// Single-port RAM, synchronous write and synchronous read, no reset.
module apb_sp_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              pclk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  // Power-up contents are zero; nothing ever clears them afterwards.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge pclk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/apb_mem_slave.sv
// APB3 completer in front of a single-port RAM, with wait states and PSLVERR.
//   state  | meaning
//   IDLE   | waiting for SETUP (psel=1, penable=0)
//   ACCESS | transfer latched; counting wait states, then pready until completion
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  apb_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;
  logic              zero_q;
  logic [DATA_W-1:0] ram_q;
  logic [ADDR_W-1:0] cur_addr;
  logic [RAM_AW-1:0] ram_addr;
  logic              load_now;
  logic              ram_re;
  logic              ram_we;

  // One bit wider so DEPTH = 2^ADDR_W is representable and never flags.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < (ADDR_W+1)'(DEPTH);
  endfunction

  always_comb begin
    cur_addr = (state == IDLE) ? paddr : addr_q;
    ram_addr = cur_addr[RAM_AW-1:0];
    load_now = 1'b0;
    if (!preset) begin
      if (state == IDLE) load_now = psel && !penable && (WAIT_CYCLES == 0);
      else               load_now = psel && !pready && (cnt == CNT_W'(1));
    end
    ram_re = load_now && in_range(cur_addr);
    ram_we = !preset && (state == ACCESS) && psel && penable && pready &&
             write_q && (pslverr == APB_OKAY);
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state   <= IDLE;
      pready  <= 1'b0;
      pslverr <= APB_OKAY;
      cnt     <= '0;
      zero_q  <= 1'b1;
    end else begin
      if (load_now) begin
        pready  <= 1'b1;
        pslverr <= in_range(cur_addr) ? APB_OKAY : APB_SLVERR;
        zero_q  <= !in_range(cur_addr);
      end
      case (state)
        IDLE: begin
          if (psel && !penable) begin
            state   <= ACCESS;
            addr_q  <= paddr;
            write_q <= pwrite;
            wdata_q <= pwdata;
            cnt     <= CNT_W'(WAIT_CYCLES);
          end
        end
        ACCESS: begin
          if (!psel) begin
            state   <= IDLE;
            pready  <= 1'b0;
            pslverr <= APB_OKAY;
          end else if (!pready) begin
            if (cnt > CNT_W'(1)) cnt <= cnt - CNT_W'(1);
          end else if (penable) begin
            state   <= IDLE;
            pready  <= 1'b0;
            pslverr <= APB_OKAY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // prdata is the RAM read register, forced to zero after reset or an error access.
  assign prdata = zero_q ? '0 : ram_q;

  apb_sp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (RAM_AW)
  ) u_ram (
    .pclk  (pclk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_apb_mem_slave.sv
// Scoreboard bench: three slave configurations share one APB bus, each with its own psel/preset.
module tb_apb_mem_slave;

  logic       clk = 1'b0;
  logic [2:0] preset;
  logic [2:0] psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [2:0] pready;
  logic [2:0] pslverr;
  logic [7:0] prdata [3];

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         inst;
    logic       rd;
    logic [7:0] data;
    logic       err;
    int         cyc;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_mem_slave #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .pclk(clk), .preset(preset[0]), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]));

  apb_mem_slave #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(3)) dut1 (
    .pclk(clk), .preset(preset[1]), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]));

  apb_mem_slave #(.DATA_W(8), .ADDR_W(8), .DEPTH(128), .WAIT_CYCLES(2)) dut2 (
    .pclk(clk), .preset(preset[2]), .psel(psel[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata[2]), .pready(pready[2]), .pslverr(pslverr[2]));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pready pulse must match the oldest expected completion.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (pready[i]) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pready inst=%0d actual=1 expected=0 (cycle %0d)", i, cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("sb_inst", i, e.inst);
          chk("latency_cycle", cyc, e.cyc);
          chk("pslverr", int'(pslverr[i]), int'(e.err));
          if (e.rd) chk("prdata", int'(prdata[i]), int'(e.data));
        end
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the completion edge.
  task automatic xfer(input int inst, input logic wr, input logic [7:0] a,
                      input logic [7:0] d, input logic [7:0] exp_d,
                      input logic exp_err, input int w);
    exp_t e;
    int   n;
    bit   done;
    e.inst = inst; e.rd = !wr; e.data = exp_d; e.err = exp_err; e.cyc = cyc + 1 + w;
    sbq.push_back(e);
    psel[inst] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    n = 0; done = 1'b0;
    while (!done && n < 40) begin
      @(negedge clk);
      if (pready[inst]) done = 1'b1;
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout inst=%0d pready actual=0 expected=1", inst);
    end
    @(posedge clk); #1;
    psel[inst] = 1'b0; penable = 1'b0;
  endtask

  initial begin
    int t0;
    preset = 3'b111; psel = 3'b000; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h00; pwdata = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_pready", int'(pready[i]), 0);
      chk("reset_pslverr", int'(pslverr[i]), 0);
      chk("reset_prdata", int'(prdata[i]), 0);
    end
    @(posedge clk); #1;
    preset = 3'b000;
    @(posedge clk); #1;

    // WAIT_CYCLES=0 basic write/read and top-address boundary
    xfer(0, 1'b1, 8'h10, 8'hA5, 8'h00, 1'b0, 0);
    xfer(0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 0);
    xfer(0, 1'b1, 8'hFF, 8'hEE, 8'h00, 1'b0, 0);
    xfer(0, 1'b0, 8'hFF, 8'h00, 8'hEE, 1'b0, 0);

    // back-to-back writes: three completions in six cycles
    t0 = cyc;
    xfer(0, 1'b1, 8'h01, 8'h01, 8'h00, 1'b0, 0);
    xfer(0, 1'b1, 8'h02, 8'h02, 8'h00, 1'b0, 0);
    xfer(0, 1'b1, 8'h03, 8'h03, 8'h00, 1'b0, 0);
    chk("b2b_cycles", cyc - t0, 6);
    xfer(0, 1'b0, 8'h01, 8'h00, 8'h01, 1'b0, 0);
    xfer(0, 1'b0, 8'h02, 8'h00, 8'h02, 1'b0, 0);
    xfer(0, 1'b0, 8'h03, 8'h00, 8'h03, 1'b0, 0);

    // WAIT_CYCLES=3: power-up read, then write/read
    xfer(1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 3);
    xfer(1, 1'b1, 8'hFF, 8'hC3, 8'h00, 1'b0, 3);
    xfer(1, 1'b0, 8'hFF, 8'h00, 8'hC3, 1'b0, 3);

    // DEPTH=128: out-of-range accesses error and must not alias onto addr 0
    xfer(2, 1'b1, 8'h00, 8'h11, 8'h00, 1'b0, 2);
    xfer(2, 1'b1, 8'h80, 8'h5A, 8'h00, 1'b1, 2);
    xfer(2, 1'b0, 8'h80, 8'h00, 8'h00, 1'b1, 2);
    xfer(2, 1'b0, 8'h00, 8'h00, 8'h11, 1'b0, 2);
    xfer(2, 1'b0, 8'h7F, 8'h00, 8'h00, 1'b0, 2);

    // reset during the 2nd ACCESS cycle of a write
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h20; pwdata = 8'h77;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    preset[2] = 1'b1;
    @(posedge clk); #1;
    preset[2] = 1'b0; psel[2] = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("rst_abort_pready", int'(pready[2]), 0);
    @(posedge clk); #1;
    xfer(2, 1'b0, 8'h20, 8'h00, 8'h00, 1'b0, 2);

    // master abort: psel dropped mid-wait on a write
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h05; pwdata = 8'h3C;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel[2] = 1'b0; penable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_pready", int'(pready[2]), 0);
    @(posedge clk); #1;
    xfer(2, 1'b0, 8'h05, 8'h00, 8'h00, 1'b0, 2);

    repeat (3) @(posedge clk);
    chk("sb_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
